pipe_hazard_ctrl: RTL and testbench

Parametrised successor to the five-stage pipeline's hazard unit. It generates per-stage enable and flush signals and the PC select for the 5-stage MIPS pipeline (fetch/decode/execute/memory/writeback). Compared with the current unit it adds:
- a registered control FSM with a dmem-wait watchdog;
- an explicit halt-drain sequence;
- a saturating stall-cycle performance counter.
It sits beside the datapath and is driven by datapath_cache_if hit signals and by stage register fields.

---
 rtl/pipe_hazard_ctrl.sv | 148 ++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// pipe_hazard_ctrl : 5-stage pipeline hazard, dmem-wait watchdog, halt drain
// Revision 1.0
// ---------------------------------------------------------------------------
module pipe_hazard_ctrl #(
  parameter int REGW      = 5,
  parameter int CNTW      = 16,
  parameter int MAX_WAIT  = 64,
  parameter int DRAIN_CYC = 2
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            ihit,
  input  logic            dhit,
  input  logic            me_ldst,
  input  logic            ex_load,
  input  logic [REGW-1:0] ex_rdst,
  input  logic [REGW-1:0] de_rs,
  input  logic [REGW-1:0] de_rt,
  input  logic            de_use_rs,
  input  logic            de_use_rt,
  input  logic            br_taken,
  input  logic            jmp_de,
  input  logic            jr_de,
  input  logic            halt_me,
  output logic            pcen,
  output logic            deen,
  output logic            exen,
  output logic            meen,
  output logic            wben,
  output logic            deflush,
  output logic            exflush,
  output logic            meflush,
  output logic [1:0]      pcsel,
  output logic            halt,
  output logic            mem_err,
  output logic [CNTW-1:0] stall_cnt
);

  localparam int WW = $clog2(MAX_WAIT + 1);
  localparam int DW = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;
  localparam logic [WW-1:0]   WAIT_SAT   = WW'(MAX_WAIT);
  localparam logic [WW-1:0]   WAIT_ERR   = WW'(MAX_WAIT - 1);
  localparam logic [DW-1:0]   DRAIN_LAST = DW'(DRAIN_CYC - 1);
  localparam logic [CNTW-1:0] CNT_MAX    = '1;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DWAIT  = 2'd1,
    DRAIN  = 2'd2,
    HALTED = 2'd3
  } state_t;

  state_t          state, state_nx;
  logic [WW-1:0]   wcnt, wcnt_nx;
  logic [DW-1:0]   dcnt, dcnt_nx;
  logic            err_nx;
  logic [CNTW-1:0] cnt_nx;
  logic            dmiss, load_use;

  assign dmiss    = me_ldst & ~dhit;
  assign load_use = ex_load & (ex_rdst != '0) &
                    ((de_use_rs & (ex_rdst == de_rs)) | (de_use_rt & (ex_rdst == de_rt)));

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state     <= RUN;
      wcnt      <= '0;
      dcnt      <= '0;
      mem_err   <= 1'b0;
      stall_cnt <= '0;
    end else begin
      state     <= state_nx;
      wcnt      <= wcnt_nx;
      dcnt      <= dcnt_nx;
      mem_err   <= err_nx;
      stall_cnt <= cnt_nx;
    end
  end

  always_comb begin
    pcen     = 1'b1;
    deen     = 1'b1;
    exen     = 1'b1;
    meen     = 1'b1;
    wben     = 1'b1;
    deflush  = 1'b0;
    exflush  = 1'b0;
    meflush  = 1'b0;
    pcsel    = 2'b00;
    halt     = 1'b0;
    state_nx = state;
    wcnt_nx  = wcnt;
    dcnt_nx  = dcnt;
    err_nx   = mem_err;
    cnt_nx   = stall_cnt;
    case (state)
      RUN, DWAIT: begin
        if (dmiss) begin
          {pcen, deen, exen, meen, wben} = 5'b00000;
          state_nx = DWAIT;
          if (wcnt != WAIT_SAT) wcnt_nx = wcnt + 1'b1;
          if (wcnt >= WAIT_ERR) err_nx = 1'b1;
        end else begin
          // A halt that arrived behind a miss drains once the miss resolves.
          state_nx = halt_me ? DRAIN : RUN;
          wcnt_nx  = '0;
          dcnt_nx  = '0;
          if (br_taken) begin
            pcsel   = 2'b01;
            deflush = 1'b1;
            exflush = 1'b1;
          end else if (load_use) begin
            pcen    = 1'b0;
            deen    = 1'b0;
            exflush = 1'b1;
          end else if (jmp_de | jr_de) begin
            pcsel   = jr_de ? 2'b11 : 2'b10;
            deflush = 1'b1;
            pcen    = ihit;
          end else if (!ihit) begin
            pcen    = 1'b0;
            deflush = 1'b1;
          end
        end
        if (!pcen && (stall_cnt != CNT_MAX)) cnt_nx = stall_cnt + 1'b1;
      end
      DRAIN: begin
        pcen    = 1'b0;
        deflush = 1'b1;
        exflush = 1'b1;
        meflush = 1'b1;
        dcnt_nx = dcnt + 1'b1;
        if (dcnt == DRAIN_LAST) begin
          state_nx = HALTED;
          dcnt_nx  = '0;
        end
      end
      default: begin
        {pcen, deen, exen, meen, wben} = 5'b00000;
        halt = 1'b1;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_pipe_hazard_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_pipe_hazard_ctrl : directed + random check against a behavioural model
// Revision 1.0
// ---------------------------------------------------------------------------
module tb_pipe_hazard_ctrl;

  localparam int REGW      = 5;
  localparam int CNTW      = 3;
  localparam int MAX_WAIT  = 4;
  localparam int DRAIN_CYC = 2;

  localparam int F_PCEN = 0, F_DEEN = 1, F_EXEN = 2, F_MEEN = 3, F_WBEN = 4;
  localparam int F_DEFL = 5, F_EXFL = 6, F_MEFL = 7, F_PCSEL = 8, F_HALT = 9;
  localparam int F_ERR = 10, F_STALL = 11;

  typedef struct packed {
    logic pcen, deen, exen, meen, wben, deflush, exflush, meflush;
    logic [1:0] pcsel;
    logic halt, mem_err;
    logic [CNTW-1:0] stall_cnt;
  } obs_t;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  logic ihit, dhit, me_ldst, ex_load, de_use_rs, de_use_rt;
  logic br_taken, jmp_de, jr_de, halt_me;
  logic [REGW-1:0] ex_rdst, de_rs, de_rt;
  logic pcen, deen, exen, meen, wben, deflush, exflush, meflush, halt, mem_err;
  logic [1:0] pcsel;
  logic [CNTW-1:0] stall_cnt;

  int errors = 0;
  int checks = 0;

  logic  lit_on = 1'b0;
  string lit_name = "";
  obs_t  lit_val, lit_mask;

  // Behavioural model state
  int miss_len = 0;
  int stalls   = 0;
  int drained  = 0;
  bit draining = 0;
  bit halted   = 0;
  bit err      = 0;

  always #5 CLK = ~CLK;

  pipe_hazard_ctrl #(
    .REGW(REGW), .CNTW(CNTW), .MAX_WAIT(MAX_WAIT), .DRAIN_CYC(DRAIN_CYC)
  ) dut (
    .CLK(CLK), .RST(RST), .ihit(ihit), .dhit(dhit), .me_ldst(me_ldst),
    .ex_load(ex_load), .ex_rdst(ex_rdst), .de_rs(de_rs), .de_rt(de_rt),
    .de_use_rs(de_use_rs), .de_use_rt(de_use_rt), .br_taken(br_taken),
    .jmp_de(jmp_de), .jr_de(jr_de), .halt_me(halt_me),
    .pcen(pcen), .deen(deen), .exen(exen), .meen(meen), .wben(wben),
    .deflush(deflush), .exflush(exflush), .meflush(meflush), .pcsel(pcsel),
    .halt(halt), .mem_err(mem_err), .stall_cnt(stall_cnt)
  );

  always @(negedge CLK) begin : cmp
    obs_t act, exp, msk;
    bit miss, lu;
    act.pcen = pcen;       act.deen = deen;       act.exen = exen;
    act.meen = meen;       act.wben = wben;       act.deflush = deflush;
    act.exflush = exflush; act.meflush = meflush; act.pcsel = pcsel;
    act.halt = halt;       act.mem_err = mem_err; act.stall_cnt = stall_cnt;

    if (RST) begin
      miss_len = 0; stalls = 0; drained = 0; draining = 0; halted = 0; err = 0;
    end
    miss = me_ldst && !dhit;
    lu   = ex_load && ex_rdst != 0 &&
           ((de_use_rs && ex_rdst == de_rs) || (de_use_rt && ex_rdst == de_rt));

    exp = '0;
    msk = '1;
    exp.mem_err   = err;
    exp.stall_cnt = CNTW'(stalls);
    exp.halt      = halted;
    if (halted) begin
      // everything low except halt
    end else if (draining) begin
      exp.deflush = 1; exp.exflush = 1; exp.meflush = 1; exp.wben = 1;
      msk.deen = 0; msk.exen = 0; msk.meen = 0; msk.pcsel = '0;
    end else begin
      {exp.pcen, exp.deen, exp.exen, exp.meen, exp.wben} = 5'b11111;
      if (miss) begin
        {exp.pcen, exp.deen, exp.exen, exp.meen, exp.wben} = 5'b00000;
      end else if (br_taken) begin
        exp.pcsel = 2'd1; exp.deflush = 1; exp.exflush = 1;
      end else if (lu) begin
        exp.pcen = 0; exp.deen = 0; exp.exflush = 1;
      end else if (jmp_de || jr_de) begin
        exp.pcsel = jr_de ? 2'd3 : 2'd2; exp.deflush = 1; exp.pcen = ihit;
      end else if (!ihit) begin
        exp.pcen = 0; exp.deflush = 1;
      end
    end

    checks++;
    if (((act ^ exp) & msk) != '0) begin
      errors++;
      $display("FAIL model t=%0t actual=%h required=%h mask=%h", $time, act, exp, msk);
    end
    if (lit_on) begin
      checks++;
      if (((act ^ lit_val) & lit_mask) != '0) begin
        errors++;
        $display("FAIL %s t=%0t actual=%h required=%h mask=%h",
                 lit_name, $time, act, lit_val, lit_mask);
      end
    end

    if (!RST) begin
      if (draining) begin
        drained++;
        if (drained == DRAIN_CYC) begin
          draining = 0;
          halted   = 1;
        end
      end else if (!halted) begin
        if (!exp.pcen && stalls < (1 << CNTW) - 1) stalls++;
        if (miss) begin
          miss_len++;
          if (miss_len >= MAX_WAIT) err = 1;
        end else begin
          miss_len = 0;
          if (halt_me) begin
            draining = 1;
            drained  = 0;
          end
        end
      end
    end
  end

  task automatic quiet();
    ihit = 1; dhit = 1; me_ldst = 0; ex_load = 0; ex_rdst = '0; de_rs = '0; de_rt = '0;
    de_use_rs = 0; de_use_rt = 0; br_taken = 0; jmp_de = 0; jr_de = 0; halt_me = 0;
  endtask

  task automatic cyc();
    @(posedge CLK);
    #1;
    lit_on = 0;
    quiet();
  endtask

  task automatic lit(input string nm);
    lit_on = 1; lit_name = nm; lit_val = '0; lit_mask = '0;
  endtask

  task automatic pin(input int f, input int v);
    case (f)
      F_PCEN:  begin lit_mask.pcen = 1;    lit_val.pcen = v[0];    end
      F_DEEN:  begin lit_mask.deen = 1;    lit_val.deen = v[0];    end
      F_EXEN:  begin lit_mask.exen = 1;    lit_val.exen = v[0];    end
      F_MEEN:  begin lit_mask.meen = 1;    lit_val.meen = v[0];    end
      F_WBEN:  begin lit_mask.wben = 1;    lit_val.wben = v[0];    end
      F_DEFL:  begin lit_mask.deflush = 1; lit_val.deflush = v[0]; end
      F_EXFL:  begin lit_mask.exflush = 1; lit_val.exflush = v[0]; end
      F_MEFL:  begin lit_mask.meflush = 1; lit_val.meflush = v[0]; end
      F_PCSEL: begin lit_mask.pcsel = '1;  lit_val.pcsel = v[1:0]; end
      F_HALT:  begin lit_mask.halt = 1;    lit_val.halt = v[0];    end
      F_ERR:   begin lit_mask.mem_err = 1; lit_val.mem_err = v[0]; end
      default: begin lit_mask.stall_cnt = '1; lit_val.stall_cnt = v[CNTW-1:0]; end
    endcase
  endtask

  initial begin
    quiet();
    cyc(); RST = 1; lit("reset");
    pin(F_STALL, 0); pin(F_HALT, 0); pin(F_ERR, 0); pin(F_PCEN, 1); pin(F_PCSEL, 0);
    cyc(); RST = 0; lit("normal");
    pin(F_PCEN, 1); pin(F_DEEN, 1); pin(F_WBEN, 1); pin(F_PCSEL, 0); pin(F_DEFL, 0);
    cyc(); ex_load = 1; ex_rdst = 5; de_rs = 5; de_use_rs = 1; lit("loaduse");
    pin(F_PCEN, 0); pin(F_DEEN, 0); pin(F_EXFL, 1); pin(F_MEEN, 1); pin(F_WBEN, 1);
    cyc(); ex_load = 1; de_use_rs = 1; lit("loaduse_r0");
    pin(F_PCEN, 1); pin(F_DEEN, 1); pin(F_EXFL, 0); pin(F_STALL, 1);

    cyc(); RST = 1;
    repeat (3) begin
      cyc(); RST = 0; me_ldst = 1; dhit = 0; lit("dmiss");
      pin(F_PCEN, 0); pin(F_DEEN, 0); pin(F_EXEN, 0); pin(F_MEEN, 0); pin(F_WBEN, 0);
    end
    cyc(); me_ldst = 1; lit("dmiss_done"); pin(F_STALL, 3); pin(F_PCEN, 1); pin(F_ERR, 0);
    cyc(); lit("dmiss_run"); pin(F_STALL, 3); pin(F_PCEN, 1); pin(F_MEEN, 1);

    cyc(); RST = 1;
    repeat (5) begin cyc(); RST = 0; me_ldst = 1; dhit = 0; end
    cyc(); lit("wdog"); pin(F_ERR, 1);
    repeat (3) cyc();
    lit("wdog_sticky"); pin(F_ERR, 1);

    cyc(); br_taken = 1; ihit = 0; ex_load = 1; ex_rdst = 7; de_rt = 7; de_use_rt = 1; jmp_de = 1;
    lit("br_combo"); pin(F_PCSEL, 1); pin(F_DEFL, 1); pin(F_EXFL, 1); pin(F_PCEN, 1);
    cyc(); jmp_de = 1; jr_de = 1; lit("jr_wins"); pin(F_PCSEL, 3); pin(F_DEFL, 1); pin(F_PCEN, 1);
    cyc(); jmp_de = 1; ex_load = 1; ex_rdst = 3; de_rs = 3; de_use_rs = 1;
    lit("jmp_held"); pin(F_PCSEL, 0); pin(F_PCEN, 0); pin(F_DEFL, 0);
    cyc(); ihit = 0; lit("imiss");
    pin(F_PCEN, 0); pin(F_DEFL, 1); pin(F_DEEN, 1); pin(F_EXEN, 1); pin(F_WBEN, 1);

    cyc(); RST = 1;
    repeat (10) begin cyc(); RST = 0; ihit = 0; end
    cyc(); lit("saturate"); pin(F_STALL, 7);

    cyc(); RST = 1;
    cyc(); RST = 0; halt_me = 1;
    repeat (2) begin
      cyc(); lit("drain");
      pin(F_PCEN, 0); pin(F_DEFL, 1); pin(F_EXFL, 1); pin(F_MEFL, 1); pin(F_WBEN, 1); pin(F_HALT, 0);
    end
    repeat (4) begin
      cyc(); ihit = 0; lit("halted");
      pin(F_HALT, 1); pin(F_PCEN, 0); pin(F_DEEN, 0); pin(F_WBEN, 0); pin(F_PCSEL, 0); pin(F_DEFL, 0);
    end

    cyc(); RST = 1;
    cyc(); RST = 0; halt_me = 1;
    cyc();
    cyc(); RST = 1; lit("rst_drain"); pin(F_HALT, 0); pin(F_PCEN, 1); pin(F_DEFL, 0); pin(F_MEFL, 0);

    repeat (2) begin cyc(); RST = 0; me_ldst = 1; dhit = 0; halt_me = 1; end
    cyc(); me_ldst = 1; halt_me = 1; lit("miss_halt_adv"); pin(F_PCEN, 1); pin(F_MEFL, 0);
    cyc(); lit("miss_then_drain"); pin(F_PCEN, 0); pin(F_MEFL, 1); pin(F_HALT, 0);

    for (int i = 0; i < 4000; i++) begin
      cyc();
      RST       = ($urandom_range(0, 149) == 0);
      ihit      = ($urandom_range(0, 4) != 0);
      dhit      = ($urandom_range(0, 9) < 7);
      me_ldst   = ($urandom_range(0, 9) < 4);
      ex_load   = $urandom_range(0, 1);
      ex_rdst   = REGW'($urandom_range(0, 3));
      de_rs     = REGW'($urandom_range(0, 3));
      de_rt     = REGW'($urandom_range(0, 3));
      de_use_rs = $urandom_range(0, 1);
      de_use_rt = $urandom_range(0, 1);
      br_taken  = ($urandom_range(0, 5) == 0);
      jmp_de    = ($urandom_range(0, 4) == 0);
      jr_de     = ($urandom_range(0, 5) == 0);
      halt_me   = ($urandom_range(0, 39) == 0);
    end

    cyc();
    @(posedge CLK);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
